aibcr3_scan_seq: RTL and testbench
==================================

# aibcr3_scan_seq

Scan-chain sequencer that drives a chain of `aibcr3_svt16_scdffcdn_cust` cells. It accepts a parallel load word over a valid/ready handshake and serially shifts it into the chain through SE/SI, gating the chain clock with CKEN. At the same time it collects the chain's scan-out (SO) into an unload word, then optionally issues one capture cycle. It sits directly upstream of the chain's first SI and directly downstream of its last scQ.

## Interface
- CHAIN_LEN, 16: number of scan cells in the chain; legal range 2..64.
- CK  in  1  clock; also the source clock of the chain's clock gate.
- CD  in  1  asynchronous active-high clear.
- LOAD_VLD  in  1  load request valid.
- LOAD_RDY  out  1  sequencer idle and accepting.
- LOAD_DATA  in  CHAIN_LEN  word to place in the chain; bit i lands in cell i.
- LOAD_CAP  in  1  sampled with LOAD_DATA; 1 = issue a capture cycle after the shift.
- SE  out  1  scan enable to all chain cells.
- SI  out  1  serial data into chain cell 0.
- CKEN  out  1  enable to the chain's ICG; the chain is clocked only when CKEN=1.
- SO  in  1  scQ of chain cell CHAIN_LEN-1.
- UNLOAD_VLD  out  1  unload word valid.
- UNLOAD_RDY  in  1  unload consumer ready.
- UNLOAD_DATA  out  CHAIN_LEN  pre-shift chain contents; bit i = old cell i.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SHIFT, CAPT, DONE.
- IDLE:
  - LOAD_RDY=1.
  - On LOAD_VLD&LOAD_RDY: shreg<=LOAD_DATA, cap_q<=LOAD_CAP, cnt<=0, go to SHIFT.
- SHIFT:
  - SE=1, CKEN=1, SI=shreg[CHAIN_LEN-1].
  - Each cycle: shreg<={shreg[CHAIN_LEN-2:0],SO}, cnt<=cnt+1.
  - When cnt==CHAIN_LEN-1: go to CAPT if cap_q, else go to DONE.
  - Shifting is MSB-first: LOAD_DATA[CHAIN_LEN-1] enters first and ends in the last cell.
- CAPT:
  - Lasts exactly 1 cycle: SE=0, CKEN=1, so the chain captures its functional D.
  - Then go to DONE.
- DONE:
  - SE=0, CKEN=0, UNLOAD_VLD=1, UNLOAD_DATA=shreg.
  - On UNLOAD_RDY: go to IDLE.
  - UNLOAD_DATA is held stable while UNLOAD_VLD=1 and UNLOAD_RDY=0.
- cnt width: $clog2(CHAIN_LEN). It never wraps, because the exit compare is exact.
- LOAD_VLD is ignored outside IDLE. No queueing.
- The unloaded word is what the chain held before this transaction, i.e. the previous capture result.

## Timing
- SE, CKEN and SI are driven directly from flops (Moore outputs), with no combinational path from inputs.
- The ICG samples CKEN, so the chain sees its first gated edge one CK edge after CKEN rises.
- Load accepted at edge E0:
  - SE/CKEN rise after E0.
  - The chain shifts on gated edges E1..E(CHAIN_LEN).
  - The capture edge is E(CHAIN_LEN+1).
- UNLOAD_VLD rises after E(CHAIN_LEN) when no capture, or after E(CHAIN_LEN+1) when capturing.
- LOAD_RDY is back to 1 one cycle after the UNLOAD handshake edge.
- Minimum transaction period: CHAIN_LEN+2 cycles, plus 1 when capturing.
- Reset values: LOAD_RDY=1, SE=0, SI=0, CKEN=0, UNLOAD_VLD=0, UNLOAD_DATA=0, BUSY=0; state=IDLE.
- Reset mid-transaction:
  - All outputs return immediately to their reset values.
  - Chain contents are undefined; no UNLOAD_VLD is produced for the aborted transaction.
- Load handshake and CD deassertion in the same cycle: the load is not taken until the first edge with CD=0.

## Structure
- Shared package `aibcr3_scan_pkg` holds:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, CAPT=2'd2, DONE=2'd3);
  - the CHAIN_LEN legal-range constants;
  - the counter-width function.
- Sub-module `aibcr3_scan_shreg` holds:
  - the CHAIN_LEN-bit parallel-load, serial-in/serial-out register;
  - the SI tap and the cycle counter.
- The top level contains the FSM and the handshakes only.

## Test plan
- Reset with CD=1 mid-SHIFT (CHAIN_LEN=4, cnt=2) -> SE, CKEN, SI, UNLOAD_VLD and BUSY drop to 0 asynchronously; LOAD_RDY=1 after CD falls.
- Chain model preloaded 4'b0110, load 4'b1010 with LOAD_CAP=0 -> SI sequence 1,0,1,0 over 4 SE=1 cycles; chain ends 4'b1010; UNLOAD_DATA=4'b0110; UNLOAD_VLD rises 4 cycles after acceptance.
- LOAD_CAP=1, chain functional D=4'b1111 -> exactly one SE=0/CKEN=1 cycle after the shift; the next transaction's UNLOAD_DATA=4'b1111.
- UNLOAD_RDY held 0 for 10 cycles -> UNLOAD_VLD and UNLOAD_DATA stable; CKEN=0; LOAD_RDY=0; LOAD_VLD pulses ignored.
- Back-to-back loads with UNLOAD_RDY=1 at CHAIN_LEN=64 -> period 66 cycles; no shift edges lost or duplicated; the data at every 64th SO sample is correct.
- CHAIN_LEN=2, load 2'b01 -> SI order 0,1; counter exits after exactly 2 shift cycles.

Source files
------------

// File: rtl/aibcr3_scan_pkg.sv
// Shared types and constants for the aibcr3 scan-chain sequencer.
// The state encoding also drives the sequencer's debug state output.
package aibcr3_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    localparam int CHAIN_LEN_MIN = 2;
    localparam int CHAIN_LEN_MAX = 64;

    // Counter width for a chain of len cells; a 2-cell chain still needs one bit.
    function automatic int cnt_width(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/aibcr3_scan_shreg.sv
// Parallel-load, serial-in/serial-out shift register with SI tap and shift counter.
// SI is registered so the chain sees a flop output, and it returns to 0 once shifting ends.
module aibcr3_scan_shreg
    import aibcr3_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 ck,
    input  logic                 cd,
    input  logic                 load,
    input  logic                 shift,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 so,
    output logic [CHAIN_LEN-1:0] shreg,
    output logic                 si,
    output logic                 last
);

    localparam int CW = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == CNT_LAST);

    // SI always carries the bit the chain will sample on the next gated edge.
    always_ff @(posedge ck or posedge cd) begin
        if (cd) begin
            shreg <= '0;
            cnt   <= '0;
            si    <= 1'b0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= '0;
            si    <= load_data[CHAIN_LEN-1];
        end else if (shift) begin
            shreg <= {shreg[CHAIN_LEN-2:0], so};
            si    <= last ? 1'b0 : shreg[CHAIN_LEN-2];
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/aibcr3_scan_seq.sv
// Scan-chain sequencer: loads a word into the chain MSB-first while unloading the old contents,
// then optionally clocks one functional capture before presenting the unload word.
module aibcr3_scan_seq
    import aibcr3_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 CK,
    input  logic                 CD,
    input  logic                 LOAD_VLD,
    output logic                 LOAD_RDY,
    input  logic [CHAIN_LEN-1:0] LOAD_DATA,
    input  logic                 LOAD_CAP,
    output logic                 SE,
    output logic                 SI,
    output logic                 CKEN,
    input  logic                 SO,
    output logic                 UNLOAD_VLD,
    input  logic                 UNLOAD_RDY,
    output logic [CHAIN_LEN-1:0] UNLOAD_DATA,
    output logic                 BUSY,
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a CK edge where valid and ready are both 1;
    // valid/data are held until then, and ready never depends combinationally on valid.

    scan_state_e state;
    logic        cap_q;
    logic        load;
    logic        shift;
    logic        last;

    assign load      = LOAD_VLD && LOAD_RDY;
    assign shift     = (state == SHIFT);
    assign dbg_state = state;

    aibcr3_scan_shreg #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_shreg (
        .ck        (CK),
        .cd        (CD),
        .load      (load),
        .shift     (shift),
        .load_data (LOAD_DATA),
        .so        (SO),
        .shreg     (UNLOAD_DATA),
        .si        (SI),
        .last      (last)
    );

    // CKEN leads the chain by one edge because the ICG samples it.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state      <= IDLE;
            cap_q      <= 1'b0;
            LOAD_RDY   <= 1'b1;
            SE         <= 1'b0;
            CKEN       <= 1'b0;
            UNLOAD_VLD <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= SHIFT;
                        cap_q    <= LOAD_CAP;
                        LOAD_RDY <= 1'b0;
                        SE       <= 1'b1;
                        CKEN     <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        SE <= 1'b0;
                        if (cap_q) begin
                            state <= CAPT;
                        end else begin
                            state      <= DONE;
                            CKEN       <= 1'b0;
                            UNLOAD_VLD <= 1'b1;
                        end
                    end
                end
                CAPT: begin
                    state      <= DONE;
                    CKEN       <= 1'b0;
                    UNLOAD_VLD <= 1'b1;
                end
                DONE: begin
                    if (UNLOAD_RDY) begin
                        state      <= IDLE;
                        UNLOAD_VLD <= 1'b0;
                        LOAD_RDY   <= 1'b1;
                        BUSY       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aibcr3_scan_seq.sv
// Bench for aibcr3_scan_seq at CHAIN_LEN 2, 4 and 64, each driving a behavioural chain
// behind a latch-based clock gate; expected SI bits and unload words go through scoreboards.
`timescale 1ns/1ps
module tb_aibcr3_scan_seq;

    // ---------------- clock / reset ----------------
    logic CK = 1'b0;
    logic CD = 1'b0;
    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc++;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- DUT signals ----------------
    logic        vld2 = 0, cap2 = 0, urdy2 = 1, rdy2, se2, si2, cken2, so2, uvld2, busy2;
    logic [1:0]  data2 = '0, udata2, st2;
    logic        vld4 = 0, cap4 = 0, urdy4 = 1, rdy4, se4, si4, cken4, so4, uvld4, busy4;
    logic [3:0]  data4 = '0, udata4;
    logic [1:0]  st4;
    logic        vld64 = 0, cap64 = 0, urdy64 = 1, rdy64, se64, si64, cken64, so64, uvld64, busy64;
    logic [63:0] data64 = '0, udata64;
    logic [1:0]  st64;

    aibcr3_scan_seq #(.CHAIN_LEN(2)) u2 (
        .CK(CK), .CD(CD), .LOAD_VLD(vld2), .LOAD_RDY(rdy2), .LOAD_DATA(data2), .LOAD_CAP(cap2),
        .SE(se2), .SI(si2), .CKEN(cken2), .SO(so2), .UNLOAD_VLD(uvld2), .UNLOAD_RDY(urdy2),
        .UNLOAD_DATA(udata2), .BUSY(busy2), .dbg_state(st2)
    );
    aibcr3_scan_seq #(.CHAIN_LEN(4)) u4 (
        .CK(CK), .CD(CD), .LOAD_VLD(vld4), .LOAD_RDY(rdy4), .LOAD_DATA(data4), .LOAD_CAP(cap4),
        .SE(se4), .SI(si4), .CKEN(cken4), .SO(so4), .UNLOAD_VLD(uvld4), .UNLOAD_RDY(urdy4),
        .UNLOAD_DATA(udata4), .BUSY(busy4), .dbg_state(st4)
    );
    aibcr3_scan_seq #(.CHAIN_LEN(64)) u64 (
        .CK(CK), .CD(CD), .LOAD_VLD(vld64), .LOAD_RDY(rdy64), .LOAD_DATA(data64), .LOAD_CAP(cap64),
        .SE(se64), .SI(si64), .CKEN(cken64), .SO(so64), .UNLOAD_VLD(uvld64), .UNLOAD_RDY(urdy64),
        .UNLOAD_DATA(udata64), .BUSY(busy64), .dbg_state(st64)
    );

    // ---------------- chain models (latch ICG + scan cells) ----------------
    logic        pre_go = 0;
    logic        en2 = 0, en4 = 0, en64 = 0;
    logic [1:0]  chain2 = '0, pre2 = '0;
    logic [3:0]  chain4 = '0, pre4 = '0, fd4 = '0;
    logic [63:0] chain64 = '0, pre64 = '0;

    always @(CK or cken2)  if (!CK) en2  <= cken2;
    always @(CK or cken4)  if (!CK) en4  <= cken4;
    always @(CK or cken64) if (!CK) en64 <= cken64;

    always @(posedge CK) begin
        if (pre_go) begin
            chain2  <= pre2;
            chain4  <= pre4;
            chain64 <= pre64;
        end else begin
            if (en2)  chain2  <= se2  ? {chain2[0], si2}       : 2'b00;
            if (en4)  chain4  <= se4  ? {chain4[2:0], si4}     : fd4;
            if (en64) chain64 <= se64 ? {chain64[62:0], si64}  : 64'd0;
        end
    end

    assign so2  = chain2[1];
    assign so4  = chain4[3];
    assign so64 = chain64[63];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int len_of(input int w);
        return (w == 0) ? 2 : (w == 1) ? 4 : 64;
    endfunction

    // {LOAD_RDY, SE, SI, CKEN, UNLOAD_VLD, BUSY}
    function automatic logic [5:0] sig_of(input int w);
        case (w)
            0:       return {rdy2, se2, si2, cken2, uvld2, busy2};
            1:       return {rdy4, se4, si4, cken4, uvld4, busy4};
            default: return {rdy64, se64, si64, cken64, uvld64, busy64};
        endcase
    endfunction

    function automatic logic [63:0] udata_of(input int w);
        case (w)
            0:       return 64'(udata2);
            1:       return 64'(udata4);
            default: return udata64;
        endcase
    endfunction

    function automatic logic urdy_of(input int w);
        return (w == 0) ? urdy2 : (w == 1) ? urdy4 : urdy64;
    endfunction

    task automatic drive(input int w, input logic v, input logic [63:0] d, input logic c);
        case (w)
            0:       begin vld2  = v; data2  = d[1:0]; cap2  = c; end
            1:       begin vld4  = v; data4  = d[3:0]; cap4  = c; end
            default: begin vld64 = v; data64 = d;      cap64 = c; end
        endcase
    endtask

    task automatic preload();
        pre_go = 1'b1;
        @(posedge CK);
        #1 pre_go = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [0:0]  exp_si_q[$];
    logic [63:0] exp_q[$];

    always @(negedge CK) begin : monitor
        logic [5:0] s;
        if (!CD) begin
            for (int w = 0; w < 3; w++) begin
                s = sig_of(w);
                if (s[4]) begin
                    if (exp_si_q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL si_extra_n%0d: SE=1 with SI=%0d and no bit expected", len_of(w), s[3]);
                    end else begin
                        check($sformatf("si_n%0d", len_of(w)), 64'(s[3]), 64'(exp_si_q.pop_front()));
                    end
                end
                if (s[1] && urdy_of(w)) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unload_extra_n%0d: got %0h with nothing expected", len_of(w), udata_of(w));
                    end else begin
                        check($sformatf("unload_n%0d", len_of(w)), udata_of(w), exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One load transaction; returns once UNLOAD_VLD is seen, with the acceptance cycle.
    task automatic run_load(input int w, input logic [63:0] d, input logic c,
                            input logic [63:0] exp_u, output int acc_cyc);
        int n;
        int k;
        int se_cnt;
        int capt_cnt;
        logic [5:0] s;
        n = len_of(w);
        k = 0;
        @(negedge CK);
        while (!sig_of(w)[5] && k < 300) begin
            @(negedge CK);
            k++;
        end
        if (!sig_of(w)[5]) begin
            n_chk++; n_err++;
            $display("FAIL rdy_timeout_n%0d: LOAD_RDY=0 after %0d cycles, required 1", n, k);
        end
        for (int i = n - 1; i >= 0; i--) exp_si_q.push_back(d[i]);
        exp_q.push_back(exp_u);
        drive(w, 1'b1, d, c);
        @(posedge CK);
        #1;
        acc_cyc = cyc;
        drive(w, 1'b0, d, c);
        k = 0; se_cnt = 0; capt_cnt = 0;
        do begin
            @(negedge CK);
            k++;
            s = sig_of(w);
            if (s[4]) se_cnt++;
            if (!s[4] && s[2]) capt_cnt++;
        end while (!s[1] && k < 300);
        check($sformatf("unload_latency_n%0d", n), 64'(k - 1), 64'(n + int'(c)));
        check($sformatf("se_cycles_n%0d", n), 64'(se_cnt), 64'(n));
        check($sformatf("capture_cycles_n%0d", n), 64'(capt_cnt), 64'(c));
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] w64 [3];
    int acc [3];
    int dummy;

    initial begin
        w64[0] = 64'hDEAD_BEEF_0123_4567;
        w64[1] = 64'h8000_0000_0000_0001;
        w64[2] = 64'h0F0F_3C3C_5A5A_FFFF;

        // Reset values.
        #1 CD = 1'b1;
        #2;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("reset_outs_n%0d", len_of(w)), 64'(sig_of(w)), 64'b100000);
            check($sformatf("reset_unload_data_n%0d", len_of(w)), udata_of(w), 64'd0);
        end
        @(negedge CK) CD = 1'b0;

        // Abort mid-SHIFT (N=4, cnt=2): only the first two bits reach the chain.
        @(negedge CK);
        exp_si_q.push_back(1'b1);
        exp_si_q.push_back(1'b0);
        vld4 = 1'b1; data4 = 4'b1011; cap4 = 1'b0;
        @(posedge CK);
        #1 vld4 = 1'b0;
        @(posedge CK);
        @(posedge CK);
        #2;
        check("abort_pre_state", 64'(st4), 64'd1);
        check("abort_pre_se_si", 64'({se4, si4}), 64'b11);
        CD = 1'b1;
        #1;
        check("abort_outs_async", 64'({se4, si4, cken4, uvld4, busy4}), 64'd0);
        @(negedge CK) CD = 1'b0;
        @(negedge CK);
        check("abort_load_rdy", 64'(rdy4), 64'd1);
        check("abort_state_idle", 64'(st4), 64'd0);
        check("abort_unload_data", 64'(udata4), 64'd0);

        // Known chain contents for every instance.
        pre2 = 2'b10; pre4 = 4'b0110; pre64 = 64'hA5A5_5A5A_C3C3_3C3C;
        preload();

        // N=4 shift without capture: old 0110 unloads, chain ends 1010.
        run_load(1, 64'b1010, 1'b0, 64'b0110, dummy);
        check("chain4_after_shift", 64'(chain4), 64'b1010);

        // N=4 shift with capture of functional D 1111.
        fd4 = 4'b1111;
        run_load(1, 64'b0011, 1'b1, 64'b1010, dummy);
        check("chain4_after_capture", 64'(chain4), 64'b1111);

        // N=4 stall: unload held while consumer not ready, load pulses ignored.
        @(posedge CK);
        #1 urdy4 = 1'b0;
        run_load(1, 64'b0000, 1'b0, 64'b1111, dummy);
        for (int i = 0; i < 10; i++) begin
            @(posedge CK);
            #1 vld4 = (i % 2 == 0);
            @(negedge CK);
            check("hold_ctrl", 64'({rdy4, cken4, uvld4, busy4, st4}), 64'b001111);
            check("hold_data", 64'(udata4), 64'b1111);
        end
        @(posedge CK);
        #1 begin vld4 = 1'b0; urdy4 = 1'b1; end
        @(negedge CK);
        @(negedge CK);
        check("after_hold_idle", 64'({rdy4, se4, busy4}), 64'b100);
        check("chain4_after_hold", 64'(chain4), 64'b0000);

        // N=2: SI order 0,1 and exit after exactly two shift cycles.
        run_load(0, 64'b01, 1'b0, 64'b10, dummy);
        check("chain2_after_shift", 64'(chain2), 64'b01);

        // N=64 back-to-back with UNLOAD_RDY=1.
        for (int k = 0; k < 3; k++) begin
            run_load(2, w64[k], 1'b0, (k == 0) ? 64'hA5A5_5A5A_C3C3_3C3C : w64[k-1], acc[k]);
        end
        check("period_64_a", 64'(acc[1] - acc[0]), 64'd66);
        check("period_64_b", 64'(acc[2] - acc[1]), 64'd66);
        check("chain64_final", chain64, w64[2]);

        repeat (4) @(negedge CK);
        check("unload_queue_drained", 64'(exp_q.size()), 64'd0);
        check("si_queue_drained", 64'(exp_si_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
